pid_seq: RTL and testbench

Sequencer that feeds the PID drive loop. Conditions raw motor-current samples into a running average and forms the signed error against the target current. Decides when the PID may update and issues a one-cycle `pid_tick` at the decimation rate, with `error` held stable around it. Detects loss of pedaling from cadence edges and parks the loop. Sits between the sensor/target logic and the PID datapath, and owns every control input the PID consumes.

---
 rtl/pid_seq_pkg.sv | 24 ++
 rtl/pid_seq_cadence_wdog.sv | 31 +++
 rtl/pid_seq.sv | 106 ++++++++++
 tb/tb_pid_seq.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/pid_seq_pkg.sv
// pid_seq_pkg: shared state type, datapath widths and timing constants for the PID sequencer.
package pid_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        LATCH,
        TICK
    } seq_state_t;

    localparam int CURR_W = 12;
    localparam int ERR_W  = 13;

    // Clocks between successive PID update strobes.
    function automatic int tick_len(input int fast_sim);
        return (fast_sim != 0) ? (1 << 15) : (1 << 20);
    endfunction

    // Clocks without a cadence edge before pedaling is considered lost.
    function automatic int np_limit(input int fast_sim);
        return (fast_sim != 0) ? (1 << 16) : (1 << 22);
    endfunction

endpackage

// File: rtl/pid_seq_cadence_wdog.sv
// cadence_wdog: saturating cadence-gap counter with a registered not_pedaling flag.
module cadence_wdog #(
    parameter int NP_LIMIT = 1 << 22
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cadence_rise,
    output logic not_pedaling
);

    localparam int               CNT_W   = $clog2(NP_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NP_LIMIT);

    logic [CNT_W-1:0] cad_cnt;

    // Counter resets saturated so the loop starts parked; a rise beats saturation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cad_cnt      <= CNT_MAX;
            not_pedaling <= 1'b1;
        end else begin
            if (cadence_rise) begin
                cad_cnt <= '0;
            end else if (cad_cnt != CNT_MAX) begin
                cad_cnt <= cad_cnt + 1'b1;
            end
            not_pedaling <= (cad_cnt == CNT_MAX);
        end
    end

endmodule

// File: rtl/pid_seq.sv
// pid_seq: current averaging, error formation and PID tick sequencing with cadence watchdog.
// Optional build macro PID_SEQ_AVG_EN enables the exponential current average.
module pid_seq
    import pid_seq_pkg::*;
#(
    parameter int FAST_SIM = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [CURR_W-1:0]        curr,
    input  logic                     curr_vld,
    input  logic [CURR_W-1:0]        target_curr,
    input  logic                     cadence_rise,
    output logic signed [ERR_W-1:0]  error,
    output logic [CURR_W-1:0]        avg_curr,
    output logic                     not_pedaling,
    output logic                     pid_tick
);

    localparam int                    TICK_LEN   = tick_len(FAST_SIM);
    localparam int                    NP_LIMIT   = np_limit(FAST_SIM);
    localparam int                    TICK_CNT_W = $clog2(TICK_LEN);
    localparam logic [TICK_CNT_W-1:0] WAIT_END   = TICK_CNT_W'(TICK_LEN - 3);

    seq_state_t            state;
    seq_state_t            state_nx;
    logic [TICK_CNT_W-1:0] tick_cnt;

    function automatic logic signed [ERR_W-1:0] curr_diff(
        input logic [CURR_W-1:0] a,
        input logic [CURR_W-1:0] b
    );
        return $signed({1'b0, a}) - $signed({1'b0, b});
    endfunction

    cadence_wdog #(
        .NP_LIMIT(NP_LIMIT)
    ) u_wdog (
        .clk         (clk),
        .rst_n       (rst_n),
        .cadence_rise(cadence_rise),
        .not_pedaling(not_pedaling)
    );

`ifdef PID_SEQ_AVG_EN
    logic [CURR_W+1:0] acc;

    // acc holds 4x the average; steady state with constant curr is 4*curr, never overflows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (curr_vld) begin
            acc <= acc - (acc >> 2) + {2'b00, curr};
        end
    end

    assign avg_curr = acc[CURR_W+1:2];
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            avg_curr <= '0;
        end else if (curr_vld) begin
            avg_curr <= curr;
        end
    end
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = WAIT;
            WAIT:    if (tick_cnt == WAIT_END) state_nx = LATCH;
            LATCH:   state_nx = TICK;
            TICK:    state_nx = WAIT;
            default: state_nx = IDLE;
        endcase
        // Losing cadence parks the loop from any state and suppresses a pending tick.
        if (not_pedaling) begin
            state_nx = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            tick_cnt <= '0;
            pid_tick <= 1'b0;
            error    <= '0;
        end else begin
            state    <= state_nx;
            pid_tick <= (state_nx == TICK);
            case (state)
                WAIT:    tick_cnt <= tick_cnt + 1'b1;
                LATCH:   tick_cnt <= tick_cnt;
                default: tick_cnt <= '0;
            endcase
            // error uses the registered average, so a sample arriving in LATCH waits a tick.
            if (not_pedaling || state == IDLE) begin
                error <= '0;
            end else if (state == LATCH) begin
                error <= curr_diff(target_curr, avg_curr);
            end
        end
    end

endmodule

// File: tb/tb_pid_seq.sv
// tb_pid_seq: directed-vector bench for pid_seq with FAST_SIM timing.
module tb_pid_seq;
    import pid_seq_pkg::*;

    localparam int TICK_LEN_T = 1 << 15;
    localparam int NP_LIMIT_T = 1 << 16;
`ifdef PID_SEQ_AVG_EN
    localparam int EXP_FIRST = 12'h100;
    localparam int EXP_INJ   = 12'hBFF;
`else
    localparam int EXP_FIRST = 12'h400;
    localparam int EXP_INJ   = 12'h000;
`endif

    logic               clk = 1'b0;
    logic               rst_n;
    logic               rst2_n;
    logic [11:0]        curr;
    logic               curr_vld;
    logic [11:0]        target_curr;
    logic               cadence_rise;
    logic signed [12:0] error, error2;
    logic [11:0]        avg_curr, avg_curr2;
    logic               not_pedaling, not_pedaling2;
    logic               pid_tick, pid_tick2;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   rs = 0;
    int   np_fall = -1;
    int   ticks = 0;
    int   t1 = 0;
    bit   cad_on = 1'b0;
    bit   strm_on = 1'b0;
    bit   np_prev = 1'b1;
    logic [11:0] strm_val = '0;

    always #5 clk = ~clk;

    pid_seq #(.FAST_SIM(1)) dut (
        .clk(clk), .rst_n(rst_n), .curr(curr), .curr_vld(curr_vld),
        .target_curr(target_curr), .cadence_rise(cadence_rise),
        .error(error), .avg_curr(avg_curr), .not_pedaling(not_pedaling),
        .pid_tick(pid_tick)
    );

    // Second instance shares stimulus but gets its own reset for the mid-tick reset case.
    pid_seq #(.FAST_SIM(1)) dut2 (
        .clk(clk), .rst_n(rst2_n), .curr(curr), .curr_vld(curr_vld),
        .target_curr(target_curr), .cadence_rise(cadence_rise),
        .error(error2), .avg_curr(avg_curr2), .not_pedaling(not_pedaling2),
        .pid_tick(pid_tick2)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     tag, got, got, exp, exp, cyc);
        end
    endtask

    // Drive inputs for the next edge, advance one clock, sample 1 time unit later.
    task automatic step();
        int nxt;
        nxt = cyc + 1;
        if (cad_on) begin
            cadence_rise = (nxt >= rs) && (nxt <= rs + 4000) && (((nxt - rs) % 1000) == 0);
        end
        if (strm_on) begin
            curr     = strm_val;
            curr_vld = ((nxt % 16) == 0);
        end
        @(posedge clk);
        #1;
        cyc = nxt;
        if (pid_tick) ticks++;
        if (np_prev && !not_pedaling) np_fall = cyc;
        np_prev = not_pedaling;
    endtask

    initial begin
        rst_n        = 1'b0;
        rst2_n       = 1'b0;
        curr         = '0;
        curr_vld     = 1'b0;
        target_curr  = '0;
        cadence_rise = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_error", int'(error), 0);
        check("rst_avg", int'(avg_curr), 0);
        check("rst_np", int'(not_pedaling), 1);
        check("rst_tick", int'(pid_tick), 0);
        @(negedge clk);
        rst_n  = 1'b1;
        rst2_n = 1'b1;

        repeat (50) step();
        check("idle_np", int'(not_pedaling), 1);
        check("idle_no_tick", ticks, 0);

        curr     = 12'h400;
        curr_vld = 1'b1;
        step();
        curr_vld = 1'b0;
        check("first_vld_avg", int'(avg_curr), EXP_FIRST);

        target_curr = 12'h800;
        strm_val    = 12'h400;
        strm_on     = 1'b1;
        repeat (10) step();

        rs     = cyc + 1;
        cad_on = 1'b1;
        step();
        check("np_after_1clk", int'(not_pedaling), 1);
        step();
        check("np_after_2clk", int'(not_pedaling), 0);

        for (int n = 0; n < 40000 && !pid_tick; n++) step();
        check("tick1_seen", int'(pid_tick), 1);
        check("tick1_latency", cyc - np_fall, TICK_LEN_T);
        check("tick1_error", int'(error), 1024);
        check("tick1_avg", int'(avg_curr), 12'h400);
        check("tick1_count", ticks, 1);
        t1 = cyc;

        check("dut2_tick_pre_rst", int'(pid_tick2), 1);
        rst2_n = 1'b0;
        #1;
        check("dut2_rst_tick", int'(pid_tick2), 0);
        check("dut2_rst_error", int'(error2), 0);
        check("dut2_rst_avg", int'(avg_curr2), 0);
        check("dut2_rst_np", int'(not_pedaling2), 1);

        step();
        check("tick_one_cycle", int'(pid_tick), 0);
        check("error_held_after_tick", int'(error), 1024);

        target_curr = 12'h000;
        strm_val    = 12'hFFF;
        while (cyc < t1 + TICK_LEN_T - 1) step();
        check("error_held_until_latch", int'(error), 1024);
        check("avg_fff", int'(avg_curr), 12'hFFF);
        check("no_early_tick", ticks, 1);

        // This edge samples the LATCH cycle: a fresh sample must not reach error.
        strm_on  = 1'b0;
        curr     = 12'h000;
        curr_vld = 1'b1;
        step();
        curr_vld = 1'b0;
        check("tick2_period", int'(pid_tick), 1);
        check("tick2_error_neg", int'(error), -4095);
        check("tick2_error_bits", int'($unsigned(error)), 13'h1001);
        check("latch_vld_avg", int'(avg_curr), EXP_INJ);

        while (cyc < rs + 4000 + NP_LIMIT_T) step();
        check("np_before_limit", int'(not_pedaling), 0);
        step();
        check("np_at_limit", int'(not_pedaling), 1);
        check("error_before_park", int'(error), -4095);
        step();
        check("error_parked", int'(error), 0);

        repeat (2000) step();
        check("no_tick_after_loss", ticks, 2);
        check("np_stays_high", int'(not_pedaling), 1);
        check("error_stays_zero", int'(error), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
